serial_adder: RTL

Bit-serial WIDTH-bit adder built around a single full-adder cell plus a carry flip-flop. Each cycle it steps one bit, LSB first, through the cell, and accumulates the result in a shift register. It sits in the arithmetic elements catalog next to the ripple-carry adder as the area-minimal alternative: it is the sequential control and datapath stage that feeds the full adder its operand bits and consumes its sum/carry outputs every cycle. It uses a start/done handshake toward the requesting controller.

---
 rtl/serial_adder.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a carry flop, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] ra, rb, rs;
  logic             c;
  logic [CW-1:0]    cnt;

  logic accept, last, s, co;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s      = ra[0] ^ rb[0] ^ c;
  assign co     = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rs  <= {s, rs[WIDTH-1:1]};
      c   <= co;
      cnt <= cnt + 1'b1;
      // Final sum includes this cycle's bit, so it is taken from the shift input, not rs.
      if (last) begin
        sum  <= {s, rs[WIDTH-1:1]};
        cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= c ^ co;
`endif
      end
    end
  end

endmodule
